// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with req/gnt/rvalid memory handshake and IF/ID register.
// At most one request outstanding; responses killed by branch/jump or reset are dropped.
module if_fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             pc_bj,
    input  logic             nop_lock_id,
    input  logic [31:0]      pc_in,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc_if_id,
    output logic [31:0]      instr_if_id,
    output logic             valid_if_id,
    output logic             fetch_busy,
    output logic [CNT_W-1:0] fetch_count
);
    typedef enum logic [1:0] {IDLE, REQ_WAIT, HOLD} state_t;

    state_t      state;
    logic [31:0] req_pc, pend_pc, pend_instr;
    logic        kill;
    logic        take, deliver, freeze;
    logic [31:0] d_pc, d_instr;

    always_comb begin
        imem_req   = (state == IDLE) & ~halt & ~rst;
        imem_addr  = imem_req ? pc_in : '0;
        fetch_busy = (state != IDLE) | (imem_req & ~imem_gnt);
        take       = ~halt & ~nop_lock_id & ~pc_bj;
        deliver    = take & ((state == REQ_WAIT & imem_rvalid & ~kill) | state == HOLD);
        d_pc       = state == HOLD ? pend_pc : req_pc;
        d_instr    = state == HOLD ? pend_instr : imem_rdata;
        // a branch overrides an ID stall so the wrong-path instruction is squashed
        freeze     = halt | (nop_lock_id & ~pc_bj);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_pc      <= '0;
            pend_pc     <= '0;
            pend_instr  <= '0;
            kill        <= 1'b0;
            pc_if_id    <= '0;
            instr_if_id <= NOP_INSTR;
            valid_if_id <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (deliver) begin
                pc_if_id    <= d_pc;
                instr_if_id <= d_instr;
                valid_if_id <= 1'b1;
                fetch_count <= fetch_count + CNT_W'(1);
            end else if (!freeze) begin
                instr_if_id <= NOP_INSTR;
                valid_if_id <= 1'b0;
            end
            case (state)
                IDLE: if (imem_req && imem_gnt) begin
                    req_pc <= pc_in;
                    kill   <= pc_bj;
                    state  <= REQ_WAIT;
                end
                REQ_WAIT: if (imem_rvalid) begin
                    kill <= 1'b0;
                    if (kill || pc_bj || take) state <= IDLE;
                    else begin
                        pend_pc    <= req_pc;
                        pend_instr <= imem_rdata;
                        state      <= HOLD;
                    end
                end else if (pc_bj) kill <= 1'b1;
                HOLD: if (!halt && (pc_bj || !nop_lock_id)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios then random traffic, checked against a transaction-level model.
module tb_if_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        halt = 1'b0, pc_bj = 1'b0, nop_lock_id = 1'b0;
    logic [31:0] pc_in = '0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] pc_if_id, instr_if_id, fetch_count;
    logic        valid_if_id, fetch_busy;

    int total = 0, bad = 0;

    // model: one fetch in flight (m_out) or one response parked (m_held), plus expected IF/ID
    bit          m_out, m_kill, m_held;
    logic [31:0] m_ipc, m_hpc, m_hins;
    logic [31:0] e_pc, e_ins, e_cnt;
    bit          e_val;

    if_fetch_unit #(.NOP_INSTR(32'h0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .halt(halt), .pc_bj(pc_bj), .nop_lock_id(nop_lock_id),
        .pc_in(pc_in), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc_if_id(pc_if_id),
        .instr_if_id(instr_if_id), .valid_if_id(valid_if_id), .fetch_busy(fetch_busy),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_kill = 0; m_held = 0;
        e_pc = 0; e_ins = 0; e_val = 0; e_cnt = 0;
    endtask

    task automatic chk_regs();
        chk("pc_if_id", pc_if_id, e_pc);
        chk("instr_if_id", instr_if_id, e_ins);
        chk("valid_if_id", {31'b0, valid_if_id}, {31'b0, e_val});
        chk("fetch_count", fetch_count, e_cnt);
    endtask

    task automatic step(input bit h, b, n, input logic [31:0] p, input bit g, rv,
                        input logic [31:0] rd);
        bit          idle, exp_req, dl;
        logic [31:0] dpc, dins;
        halt = h; pc_bj = b; nop_lock_id = n; pc_in = p;
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        #1;
        idle    = !m_out && !m_held;
        exp_req = idle && !h;
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        chk("imem_addr", imem_addr, exp_req ? p : 32'h0);
        chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, !idle || (exp_req && !g)});
        @(posedge clk);
        dl = 0; dpc = 0; dins = 0;
        if (m_out && rv) begin
            m_out = 0;
            if (!(m_kill || b)) begin
                if (h || n) begin m_held = 1; m_hpc = m_ipc; m_hins = rd; end
                else begin dl = 1; dpc = m_ipc; dins = rd; end
            end
        end else if (m_out && b) m_kill = 1;
        else if (m_held && !h) begin
            if (b) m_held = 0;
            else if (!n) begin m_held = 0; dl = 1; dpc = m_hpc; dins = m_hins; end
        end
        if (idle && !h && g) begin m_out = 1; m_ipc = p; m_kill = b; end
        if (dl) begin e_pc = dpc; e_ins = dins; e_val = 1; e_cnt++; end
        else if (!(h || (n && !b))) begin e_ins = 0; e_val = 0; end
        @(negedge clk);
        chk_regs();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk_regs();
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        rst = 0;
        // fetch with two-cycle response latency
        step(0, 0, 0, 5, 1, 0, 0);
        step(0, 0, 0, 5, 0, 0, 0);
        step(0, 0, 0, 5, 0, 1, 32'h2008_0001);
        chk("s1_pc", pc_if_id, 5);
        chk("s1_instr", instr_if_id, 32'h2008_0001);
        chk("s1_cnt", fetch_count, 1);
        // branch while waiting kills the response
        step(0, 0, 0, 8, 1, 0, 0);
        step(0, 1, 0, 20, 0, 0, 0);
        step(0, 0, 0, 20, 0, 1, 32'hDEAD_BEEF);
        chk("s2_valid", {31'b0, valid_if_id}, 32'h0);
        chk("s2_instr", instr_if_id, 32'h0);
        chk("s2_cnt", fetch_count, 1);
        step(0, 0, 0, 20, 1, 0, 0);
        step(0, 0, 0, 20, 0, 1, 32'h0000_0020);
        // ID stall over the response parks it, release delivers it
        step(0, 0, 0, 12, 1, 0, 0);
        step(0, 0, 1, 12, 0, 0, 0);
        step(0, 0, 1, 12, 0, 1, 32'h1234_5678);
        step(0, 0, 1, 12, 0, 0, 0);
        chk("s3_hold_pc", pc_if_id, 20);
        chk("s3_hold_busy", {31'b0, fetch_busy}, 32'h1);
        step(0, 0, 0, 13, 0, 0, 0);
        chk("s3_pc", pc_if_id, 12);
        chk("s3_instr", instr_if_id, 32'h1234_5678);
        chk("s3_valid", {31'b0, valid_if_id}, 32'h1);
        // halt in IDLE
        repeat (4) step(1, 0, 0, 40, 1, 0, 0);
        step(0, 0, 0, 40, 0, 0, 0);
        // reset mid-transaction, then a stale response
        step(0, 0, 0, 44, 1, 0, 0);
        #2 rst = 1;
        #1;
        chk("arst_pc", pc_if_id, 0);
        chk("arst_valid", {31'b0, valid_if_id}, 32'h0);
        chk("arst_cnt", fetch_count, 0);
        chk("arst_req", {31'b0, imem_req}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0;
        step(0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
        chk("stale_cnt", fetch_count, 0);
        // back-to-back fetches
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, i, 1, 0, 0);
            step(0, 0, 0, i + 1, 0, 1, 32'h100 + i);
        end
        chk("b2b_cnt", fetch_count, 4);
        chk("b2b_pc", pc_if_id, 3);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit h, b;
            h = ($urandom % 8) == 0;
            b = !h && ($urandom % 6) == 0;
            step(h, b, ($urandom % 4) == 0, $urandom, $urandom % 2,
                 m_out && ($urandom % 3) == 0, $urandom);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
